// File: rtl/vga_frame_reader_if.sv
// rtl/vga_frame_reader_if.sv - frame-buffer read port and VGA pin bundle for vga_frame_reader
interface vga_frame_reader_if;
  logic [9:0] x_addr;
  logic [9:0] y_addr;
  logic [7:0] value;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic       frame_start;

  modport master (
    output x_addr, y_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
    input  value
  );

  modport slave (
    input  x_addr, y_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, frame_start,
    output value
  );
endinterface

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - SVGA raster timing, frame-buffer address generation and pixel realignment.
// Optional test pattern source selected by macro VGA_TEST_PATTERN_EN.
module vga_frame_reader #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int SYNC_POL = 1,
  parameter int RD_LAT   = 2
) (
  input logic rd_clk,
  input logic reset,
`ifdef VGA_TEST_PATTERN_EN
  input logic pattern_en,
`endif
  vga_frame_reader_if.master bus
);

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic        SYNC_ON = (SYNC_POL != 0);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_act, v_act, s0_hs, s0_vs;

  logic [9:0]  x_addr_q, y_addr_q;
  logic        a_hs, a_vs, a_act, frame_start_q;

  logic [RD_LAT-1:0] hs_p, vs_p, act_p;
  logic [7:0]  pix_src, pix_q;
  logic        hs_q, vs_q, blank_n_q;

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 11'd1;
    end
  end

  assign h_act = (h_cnt < H_ACT);
  assign v_act = (v_cnt < V_ACT);
  assign s0_hs = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign s0_vs = (v_cnt >= V_SS) && (v_cnt < V_SE);

  // Blanking addresses are forced to 0 so the buffer never sees an out-of-range index.
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      x_addr_q      <= '0;
      y_addr_q      <= '0;
      a_hs          <= 1'b0;
      a_vs          <= 1'b0;
      a_act         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_addr_q      <= h_act ? h_cnt[9:0] : 10'd0;
      y_addr_q      <= v_act ? v_cnt : 10'd0;
      a_hs          <= s0_hs;
      a_vs          <= s0_vs;
      a_act         <= h_act && v_act;
      frame_start_q <= (h_cnt == 11'd0) && (v_cnt == 10'd0);
    end
  end

  // Delay line matching the frame-buffer read latency.
  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      hs_p  <= '0;
      vs_p  <= '0;
      act_p <= '0;
    end else begin
      hs_p[0]  <= a_hs;
      vs_p[0]  <= a_vs;
      act_p[0] <= a_act;
      for (int i = 1; i < RD_LAT; i++) begin
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
        act_p[i] <= act_p[i-1];
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic              a_pat;
  logic [RD_LAT-1:0] sel_p;
  logic [7:0]        pat_p [RD_LAT];

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      a_pat <= 1'b0;
      sel_p <= '0;
      for (int i = 0; i < RD_LAT; i++) pat_p[i] <= '0;
    end else begin
      a_pat    <= pattern_en;
      sel_p[0] <= a_pat;
      pat_p[0] <= {x_addr_q[9:3], y_addr_q[3]};
      for (int i = 1; i < RD_LAT; i++) begin
        sel_p[i] <= sel_p[i-1];
        pat_p[i] <= pat_p[i-1];
      end
    end
  end

  assign pix_src = sel_p[RD_LAT-1] ? pat_p[RD_LAT-1] : bus.value;
`else
  assign pix_src = bus.value;
`endif

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      hs_q      <= !SYNC_ON;
      vs_q      <= !SYNC_ON;
      blank_n_q <= 1'b0;
      pix_q     <= '0;
    end else begin
      hs_q      <= hs_p[RD_LAT-1] ? SYNC_ON : !SYNC_ON;
      vs_q      <= vs_p[RD_LAT-1] ? SYNC_ON : !SYNC_ON;
      blank_n_q <= act_p[RD_LAT-1];
      pix_q     <= act_p[RD_LAT-1] ? pix_src : 8'd0;
    end
  end

  assign bus.x_addr      = x_addr_q;
  assign bus.y_addr      = y_addr_q;
  assign bus.frame_start = frame_start_q;
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_r       = pix_q;
  assign bus.vga_g       = pix_q;
  assign bus.vga_b       = pix_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb/tb_vga_frame_reader.sv - directed vectors and raster model for vga_frame_reader (short vertical geometry)
module tb_vga_frame_reader;

  localparam int VA = 20;
  localparam int VF = 3;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VT = VA + VF + VS + VB;
  localparam int HT = 1040;
  localparam int FT = HT * VT;

  typedef struct {
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic       b;
    logic       hs;
    logic       vs;
    logic [7:0] pix;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
`ifdef VGA_TEST_PATTERN_EN
  logic pattern_en;
`endif

  vga_frame_reader_if bus ();

  vga_frame_reader #(
    .V_ACTIVE(VA),
    .V_FP    (VF),
    .V_SYNC  (VS),
    .V_BP    (VB)
  ) dut (
    .rd_clk(clk),
    .reset (reset),
`ifdef VGA_TEST_PATTERN_EN
    .pattern_en(pattern_en),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  vec_t tbl[$];
  int   k, phase, ti, passed, total, errs, nfs, nb, nh, nv;
  logic model_on;
  logic [7:0] v1, v2;

  function automatic logic [47:0] pack_out();
    return {bus.x_addr, bus.y_addr, bus.frame_start, bus.vga_blank_n, bus.vga_hs,
            bus.vga_vs, bus.vga_r, bus.vga_g, bus.vga_b};
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input int c, input int x, input int y, input int fs, input int b,
                     input int hs, input int vs, input int p);
    vec_t t;
    t.cyc = c; t.x = 10'(x); t.y = 10'(y); t.fs = 1'(fs); t.b = 1'(b);
    t.hs = 1'(hs); t.vs = 1'(vs); t.pix = 8'(p);
    tbl.push_back(t);
  endtask

  // One clock: advance, sample at the falling edge, check, then drive the 2-deep buffer model.
  task automatic step();
    int a, o, ha, va, ho, vo;
    logic [9:0] ex, ey;
    logic efs, eb, ehs, evs;
    logic [7:0] ep;
    @(posedge clk);
    k++;
    @(negedge clk);
    a = k - 1;
    ha = a % HT;
    va = (a / HT) % VT;
    ex = (ha < 800) ? 10'(ha) : 10'd0;
    ey = (va < VA) ? 10'(va) : 10'd0;
    efs = ((a % FT) == 0);
    if (k < 4) begin
      eb = 1'b0; ehs = 1'b0; evs = 1'b0; ep = 8'd0;
    end else begin
      o = k - 4;
      ho = o % HT;
      vo = (o / HT) % VT;
      eb = (ho < 800) && (vo < VA);
      ehs = (ho >= 856) && (ho < 976);
      evs = (vo >= VA + VF) && (vo < VA + VF + VS);
      ep = eb ? 8'(ho) : 8'd0;
    end
    if (model_on && pack_out() !== {ex, ey, efs, eb, ehs, evs, ep, ep, ep}) begin
      errs++;
      if (errs <= 5)
        $display("model diff at k=%0d phase=%0d: got %h want %h", k, phase, pack_out(),
                 {ex, ey, efs, eb, ehs, evs, ep, ep, ep});
    end
    if (phase == 0) begin
      if (k >= 4 && k <= 1043) begin
        nb += int'(bus.vga_blank_n);
        nh += int'(bus.vga_hs);
      end
      if (k >= 4 && k <= FT + 3) nv += int'(bus.vga_vs);
      if (k <= 2 * FT + 1) nfs += int'(bus.frame_start);
      if (ti < tbl.size() && tbl[ti].cyc == k) begin
        check($sformatf("vec_k%0d", k), pack_out(),
              {tbl[ti].x, tbl[ti].y, tbl[ti].fs, tbl[ti].b, tbl[ti].hs, tbl[ti].vs,
               tbl[ti].pix, tbl[ti].pix, tbl[ti].pix});
        ti++;
      end
    end
    bus.value = v2;
    v2 = v1;
    v1 = bus.x_addr[7:0];
  endtask

  initial begin
    reset = 1'b0;
    bus.value = 8'd0;
    v1 = 8'd0; v2 = 8'd0;
    k = 0; phase = 0; ti = 0; passed = 0; total = 0;
    errs = 0; nfs = 0; nb = 0; nh = 0; nv = 0;
    model_on = 1'b1;
`ifdef VGA_TEST_PATTERN_EN
    pattern_en = 1'b0;
`endif
    //   cyc    x    y  fs  b  hs vs pix
    add(1,      0,   0, 1, 0, 0, 0, 'h00);
    add(2,      1,   0, 0, 0, 0, 0, 'h00);
    add(3,      2,   0, 0, 0, 0, 0, 'h00);
    add(4,      3,   0, 0, 1, 0, 0, 'h00);
    add(5,      4,   0, 0, 1, 0, 0, 'h01);
    add(259,  258,   0, 0, 1, 0, 0, 'hFF);
    add(260,  259,   0, 0, 1, 0, 0, 'h00);
    add(800,  799,   0, 0, 1, 0, 0, 'h1C);
    add(801,    0,   0, 0, 1, 0, 0, 'h1D);
    add(803,    0,   0, 0, 1, 0, 0, 'h1F);
    add(804,    0,   0, 0, 0, 0, 0, 'h00);
    add(859,    0,   0, 0, 0, 0, 0, 'h00);
    add(860,    0,   0, 0, 0, 1, 0, 'h00);
    add(979,    0,   0, 0, 0, 1, 0, 'h00);
    add(980,    0,   0, 0, 0, 0, 0, 'h00);
    add(1041,   0,   1, 0, 0, 0, 0, 'h00);
    add(1042,   1,   1, 0, 0, 0, 0, 'h00);
    add(1044,   3,   1, 0, 1, 0, 0, 'h00);
    add(1045,   4,   1, 0, 1, 0, 0, 'h01);
    add(19764,  3,  19, 0, 1, 0, 0, 'h00);
    add(20803,  2,   0, 0, 0, 0, 0, 'h00);
    add(20804,  3,   0, 0, 0, 0, 0, 'h00);
    add(23923,  2,   0, 0, 0, 0, 0, 'h00);
    add(23924,  3,   0, 0, 0, 0, 1, 'h00);
    add(24780,  0,   0, 0, 0, 1, 1, 'h00);
    add(26003,  2,   0, 0, 0, 0, 1, 'h00);
    add(26004,  3,   0, 0, 0, 0, 0, 'h00);
    add(28081,  0,   0, 1, 0, 0, 0, 'h00);
    add(28082,  1,   0, 0, 0, 0, 0, 'h00);
    add(28084,  3,   0, 0, 1, 0, 0, 'h00);
    add(28085,  4,   0, 0, 1, 0, 0, 'h01);
    add(56161,  0,   0, 1, 0, 0, 0, 'h00);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", pack_out(), 48'h0);
    reset = 1'b1;

    // Two full frames plus a mid-frame reset at h_cnt=400, v_cnt=5 of the third.
    while (k < 2 * FT + 5 * HT + 400) step();
    check("pre_reset_visible", {47'h0, bus.vga_blank_n}, 48'h1);
    reset = 1'b0;
    #1;
    check("async_reset", pack_out(), 48'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("held_reset", pack_out(), 48'h0);
    reset = 1'b1;
    k = 0;
    phase = 1;
    step();
    check("restart_frame_start", pack_out(), {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0});
    repeat (3) step();
    check("restart_first_pixel", pack_out(), {10'd3, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0});
    while (k < 1100) step();

    check_int("model_stream_errors", errs, 0);
    check_int("frame_start_count", nfs, 3);
    check_int("blank_n_per_line", nb, 800);
    check_int("hsync_per_line", nh, 120);
    check_int("vsync_cycles_per_frame", nv, VS * HT);

`ifdef VGA_TEST_PATTERN_EN
    reset = 1'b0;
    @(negedge clk);
    pattern_en = 1'b1;
    model_on = 1'b0;
    phase = 2;
    k = 0;
    reset = 1'b1;
    while (k < 8 * HT + 64 + 4) step();
    check("pattern_col64_row8", {40'h0, bus.vga_g}, 48'h11);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Read-side display controller for the stereo camera frame buffer. Generates 800x600 SVGA raster timing from the 50 MHz read clock, drives the pixel x/y read address into the dual-clock frame buffer, and realigns the returned 8-bit grayscale pixel with delayed sync/blank so the VGA DAC receives a coherent pixel stream. It sits between the capture/frame-buffer path (camera writes on `pclk`) and the board VGA pins.

## Interface

Parameters:
- `H_ACTIVE`, 800: visible pixels per line
- `H_FP`, 56: horizontal front porch, in clocks
- `H_SYNC`, 120: horizontal sync width, in clocks
- `H_BP`, 64: horizontal back porch, in clocks
- `V_ACTIVE`, 600: visible lines per frame
- `V_FP`, 37: vertical front porch, in lines
- `V_SYNC`, 6: vertical sync width, in lines
- `V_BP`, 23: vertical back porch, in lines
- `SYNC_POL`, 1: asserted level of hsync/vsync (1 = positive, per SVGA 72 Hz)
- `RD_LAT`, 2: frame-buffer read latency, address to `value`, in clocks

Ports:
- `rd_clk` input 1: pixel clock, 50 MHz; same clock as the frame-buffer read port
- `reset` input 1: asynchronous, active-low reset
- `x_addr` output 10: frame-buffer column address
- `y_addr` output 10: frame-buffer row address
- `value` input 8: frame-buffer pixel, valid `RD_LAT` clocks after the address
- `vga_r`, `vga_g`, `vga_b` output 8 each: pixel colour (grayscale replicated)
- `vga_hs` output 1: horizontal sync
- `vga_vs` output 1: vertical sync
- `vga_blank_n` output 1: high during the visible region
- `frame_start` output 1: one-clock pulse at pixel (0,0) of the address stream
- `pattern_en` input 1: present only with `VGA_TEST_PATTERN_EN`

## Operation

- Horizontal counter `h_cnt`:
  - 11 bits, counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 1040.
  - Wraps to 0 and increments `v_cnt`.
- Vertical counter `v_cnt`:
  - 10 bits, counts 0..V_TOTAL-1, where V_TOTAL = 666.
  - Wraps to 0 when both counters are at their terminal count in the same cycle.
- Raster regions are ordered active, front porch, sync, back porch.
  - hsync asserted for `h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for `v_cnt` in the same pattern using the vertical parameters.
- Address generation, registered:
  - `x_addr` = `h_cnt` when `h_cnt` < H_ACTIVE, else 0.
  - `y_addr` = `v_cnt` when `v_cnt` < V_ACTIVE, else 0.
  - Addresses outside the active region are don't-care to the buffer, but must stay in range (< 800 / < 600).
- Stage-0 active = (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
- Alignment pipeline:
  - Stage-0 hs, vs and active are delayed RD_LAT+1 stages, so they line up with the registered pixel output.
- Pixel output register:
  - If the delayed active bit is set: `vga_r`=`vga_g`=`vga_b`=`value`.
  - Otherwise all three are 0.
- `frame_start` is asserted in the same cycle that `x_addr`=0 and `y_addr`=0 are first presented for a frame. It is not delayed.
- No handshakes; the block free-runs.

## Timing

- Reset state, while `reset`=0:
  - `h_cnt`=`v_cnt`=0
  - `x_addr`=`y_addr`=0
  - `vga_hs`=`vga_vs`=!SYNC_POL
  - `vga_blank_n`=0
  - all colour outputs 0
  - `frame_start`=0
  - all pipeline stages cleared to inactive
- First rising edge after deassertion: counters advance to `h_cnt`=1.
- Address (0,0) is presented on the first edge after reset release, and `frame_start` pulses in that same cycle.
- Latency from address edge to VGA output edge is exactly RD_LAT+1 = 3 clocks, for pixel, sync and blank alike.
- Line period is 1040 clocks and frame period is 1040×666 = 692,640 clocks (~72.2 Hz).
- Reset asserted mid-frame: all state clears immediately (asynchronous). Raster restarts at (0,0) on release.
- `value` is sampled only through the aligned path. Data arriving during blanking is discarded.

## Configuration

- Macro: `VGA_TEST_PATTERN_EN`.
- Defined:
  - Adds the `pattern_en` port.
  - When `pattern_en`=1, the pixel register loads {`x_addr`[9:3], `y_addr`[3]} instead of `value`: horizontal ramp with a row-alternating LSB.
  - The pattern value is taken from the address stage and delayed RD_LAT stages, so it aligns identically to real data.
  - `pattern_en` is sampled at the address stage.
- Undefined: the port is absent and the output is always `value`.

## Test plan

- Release reset with `value` tied to 8'hAA:
  - first `vga_blank_n` rise occurs 3 clocks after `frame_start`
  - `vga_r`=8'hAA for exactly 800 clocks per line, 0 otherwise
- Count hsync: asserted 120 clocks, starting 856 clocks after line start; period 1040 clocks.
- Count vsync over two frames:
  - asserted 6 lines starting at line 637
  - `frame_start` pulses every 692,640 clocks
- Buffer model returning `value` = `x_addr`[7:0] with 2-clock latency: on visible pixels, `vga_g` at output column n equals n[7:0], with no off-by-one at columns 0 and 799.
- Assert `reset` low at `h_cnt`=400, `v_cnt`=300:
  - outputs go to reset values without waiting for a clock edge
  - after release, `frame_start` fires on the first edge
- With `VGA_TEST_PATTERN_EN` and `pattern_en`=1: pixel at column 64, row 8 outputs 8'h11, independent of `value`.
